// File: rtl/ram_acc_pkg.sv
// Shared constants and FSM state type for the CPU RAM access controller.
// Optional zero-fill after reset is enabled by defining RAM_ACC_CLEAR_EN.
package ram_acc_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 128;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    ISSUE,
    CAPT,
    RESP
  } state_e;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Load/store request and load-response bundle.
// master = CPU requester, slave = ram_access_ctrl.
interface ram_access_ctrl_if;
  import ram_acc_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    output req_ready,
    output rsp_valid,
    output rsp_rdata
  );

endinterface

// File: rtl/ram_clear_seq.sv
// Post-reset zero-fill sequencer for RAM port 0 (built only with RAM_ACC_CLEAR_EN).
// Writes address 0..DEPTH-1 once, then parks at DEPTH-1 with busy low.
module ram_clear_seq
  import ram_acc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic              busy_q, busy_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Start writing one cycle after reset, step once per cycle, stop at the top.
  always_comb begin
    busy_d = busy_q;
    wr_d   = wr_q;
    addr_d = addr_q;
    if (busy_q) begin
      if (!wr_q) begin
        wr_d   = 1'b1;
        addr_d = '0;
      end else if (addr_q == LAST_ADDR) begin
        wr_d   = 1'b0;
        busy_d = 1'b0;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  // Sequencer registers; busy comes out of reset high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b1;
      wr_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      busy_q <= busy_d;
      wr_q   <= wr_d;
      addr_q <= addr_d;
    end
  end

  assign busy  = busy_q;
  assign wr_en = wr_q;
  assign addr  = addr_q;
  assign last  = wr_q && (addr_q == LAST_ADDR);

endmodule

// File: rtl/ram_access_ctrl.sv
// CPU-side initiator for the 2-port 128x16 RAM: one load/store at a time on port 1.
// Define RAM_ACC_CLEAR_EN to zero-fill the RAM through port 0 after every reset.
module ram_access_ctrl
  import ram_acc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  ram_access_ctrl_if.slave  bus,
  output logic              busy,
  output logic              ram_read_en0,
  output logic              ram_write_en0,
  output logic [ADDR_W-1:0] ram_addr0,
  output logic [DATA_W-1:0] ram_din0,
  output logic              ram_read_en1,
  output logic              ram_write_en1,
  output logic [ADDR_W-1:0] ram_addr1,
  output logic [DATA_W-1:0] ram_din1,
  input  logic [DATA_W-1:0] ram_dout1
);

  logic clr_last;

`ifdef RAM_ACC_CLEAR_EN
  localparam state_e RST_STATE = CLEAR;

  ram_clear_seq u_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .busy  (busy),
    .wr_en (ram_write_en0),
    .addr  (ram_addr0),
    .last  (clr_last)
  );
`else
  localparam state_e RST_STATE = IDLE;

  assign busy          = 1'b0;
  assign ram_write_en0 = 1'b0;
  assign ram_addr0     = '0;
  assign clr_last      = 1'b0;
`endif

  assign ram_read_en0 = 1'b0;
  assign ram_din0     = '0;

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              re1_q, re1_d;
  logic              we1_q, we1_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [DATA_W-1:0] din1_q, din1_d;

  logic accept;

  assign accept = bus.req_valid && req_ready_q;

  // Next state and next registered outputs; ready is 1 exactly when IDLE follows.
  always_comb begin
    state_d     = state_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    re1_d       = 1'b0;
    we1_d       = 1'b0;
    addr1_d     = addr1_q;
    din1_d      = din1_q;
    unique case (state_q)
      CLEAR: begin
        if (clr_last) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end
      end
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
          addr1_d = bus.req_addr;
          din1_d  = bus.req_wdata;
          we1_d   = bus.req_we;
          re1_d   = !bus.req_we;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ISSUE: begin
        if (we1_q) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end else begin
          state_d = CAPT;
        end
      end
      CAPT: begin
        state_d     = RESP;
        rsp_rdata_d = ram_dout1;
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and port-1 / response registers; reset aborts any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      re1_q       <= 1'b0;
      we1_q       <= 1'b0;
      addr1_q     <= '0;
      din1_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      re1_q       <= re1_d;
      we1_q       <= we1_d;
      addr1_q     <= addr1_d;
      din1_q      <= din1_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign ram_read_en1  = re1_q;
  assign ram_write_en1 = we1_q;
  assign ram_addr1     = addr1_q;
  assign ram_din1      = din1_q;

endmodule
